mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single lower-level memory port shared by the instruction cache and the data cache.
- Accepts one block-sized transaction at a time from either cache miss path.
- Registers the transaction and drives it to memory.
- Waits for the memory response and routes it back to the originating cache.
- Sits between the cache lowX ports and the memory/bus interface.

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter that sequences one block transaction at a time onto a shared memory port.
// Build option: define MEM_ARB_DCACHE_PRIO_EN for fixed dcache priority instead of round-robin.
module mem_arbiter #(
    parameter int XLEN     = 32,
    parameter int BLK_SIZE = 128
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ic_req_valid_i,
    output logic                ic_req_ready_o,
    input  logic [XLEN-1:0]     ic_req_addr_i,
    input  logic                ic_req_uncached_i,
    output logic                ic_res_valid_o,
    output logic [BLK_SIZE-1:0] ic_res_blk_o,
    input  logic                dc_req_valid_i,
    output logic                dc_req_ready_o,
    input  logic [XLEN-1:0]     dc_req_addr_i,
    input  logic                dc_req_rw_i,
    input  logic [BLK_SIZE-1:0] dc_req_data_i,
    input  logic                dc_req_uncached_i,
    output logic                dc_res_valid_o,
    output logic [BLK_SIZE-1:0] dc_res_blk_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [XLEN-1:0]     mem_req_addr_o,
    output logic                mem_req_rw_o,
    output logic [BLK_SIZE-1:0] mem_req_data_o,
    output logic                mem_req_uncached_o,
    input  logic                mem_res_valid_i,
    input  logic [BLK_SIZE-1:0] mem_res_blk_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    state_t              state_reg;
    logic                owner_reg;
    logic [XLEN-1:0]     addr_reg;
    logic                rw_reg;
    logic                uncached_reg;
    logic [BLK_SIZE-1:0] data_reg;
    logic                mem_req_valid_reg;
    logic                grant_ic;
    logic                grant_dc;
    logic                res_fire;
    logic [1:0]          res_valid_reg;
    logic [BLK_SIZE-1:0] res_blk_reg [2];

`ifdef MEM_ARB_DCACHE_PRIO_EN
    always_comb begin
        grant_dc = dc_req_valid_i;
        grant_ic = ic_req_valid_i && !dc_req_valid_i;
    end
`else
    logic last_grant_reg;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_ic = ic_req_valid_i && (!dc_req_valid_i || (last_grant_reg == OWN_DC));
        grant_dc = dc_req_valid_i && (!ic_req_valid_i || (last_grant_reg == OWN_IC));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_reg <= OWN_DC;
        end else if ((state_reg == IDLE) && (grant_ic || grant_dc)) begin
            last_grant_reg <= grant_dc ? OWN_DC : OWN_IC;
        end
    end
`endif

    assign ic_req_ready_o = (state_reg == IDLE) && grant_ic;
    assign dc_req_ready_o = (state_reg == IDLE) && grant_dc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg         <= IDLE;
            owner_reg         <= OWN_IC;
            addr_reg          <= '0;
            rw_reg            <= 1'b0;
            uncached_reg      <= 1'b0;
            data_reg          <= '0;
            mem_req_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_dc) begin
                        owner_reg         <= OWN_DC;
                        addr_reg          <= dc_req_addr_i;
                        rw_reg            <= dc_req_rw_i;
                        data_reg          <= dc_req_data_i;
                        uncached_reg      <= dc_req_uncached_i;
                        mem_req_valid_reg <= 1'b1;
                        state_reg         <= REQ;
                    end else if (grant_ic) begin
                        // Instruction fetches are always reads with no payload.
                        owner_reg         <= OWN_IC;
                        addr_reg          <= ic_req_addr_i;
                        rw_reg            <= 1'b0;
                        data_reg          <= '0;
                        uncached_reg      <= ic_req_uncached_i;
                        mem_req_valid_reg <= 1'b1;
                        state_reg         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_reg <= 1'b0;
                        state_reg         <= RESP;
                    end
                end
                RESP: begin
                    if (mem_res_valid_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg         <= IDLE;
                    mem_req_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Responses outside RESP are protocol errors and are dropped here.
    assign res_fire = (state_reg == RESP) && mem_res_valid_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_res
            localparam logic CH_OWNER = (gi == 1) ? OWN_DC : OWN_IC;
            logic res_hit;

            assign res_hit = res_fire && (owner_reg == CH_OWNER);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    res_valid_reg[gi] <= 1'b0;
                    res_blk_reg[gi]   <= '0;
                end else begin
                    res_valid_reg[gi] <= res_hit;
                    if (res_hit) begin
                        res_blk_reg[gi] <= mem_res_blk_i;
                    end
                end
            end
        end
    endgenerate

    assign ic_res_valid_o     = res_valid_reg[0];
    assign ic_res_blk_o       = res_blk_reg[0];
    assign dc_res_valid_o     = res_valid_reg[1];
    assign dc_res_blk_o       = res_blk_reg[1];
    assign mem_req_valid_o    = mem_req_valid_reg;
    assign mem_req_addr_o     = addr_reg;
    assign mem_req_rw_o       = rw_reg;
    assign mem_req_data_o     = data_reg;
    assign mem_req_uncached_o = uncached_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected responses are queued when memory answers and popped on the response pulse.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         ic_req_valid_i, ic_req_ready_o, ic_req_uncached_i, ic_res_valid_o;
    logic [31:0]  ic_req_addr_i;
    logic [127:0] ic_res_blk_o;
    logic         dc_req_valid_i, dc_req_ready_o, dc_req_rw_i, dc_req_uncached_i, dc_res_valid_o;
    logic [31:0]  dc_req_addr_i;
    logic [127:0] dc_req_data_i, dc_res_blk_o;
    logic         mem_req_valid_o, mem_req_ready_i, mem_req_rw_o, mem_req_uncached_o, mem_res_valid_i;
    logic [31:0]  mem_req_addr_o;
    logic [127:0] mem_req_data_o, mem_res_blk_i;

    typedef struct {
        bit           dc;
        logic [127:0] blk;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors    = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(32), .BLK_SIZE(128)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o),
        .ic_req_addr_i(ic_req_addr_i), .ic_req_uncached_i(ic_req_uncached_i),
        .ic_res_valid_o(ic_res_valid_o), .ic_res_blk_o(ic_res_blk_o),
        .dc_req_valid_i(dc_req_valid_i), .dc_req_ready_o(dc_req_ready_o),
        .dc_req_addr_i(dc_req_addr_i), .dc_req_rw_i(dc_req_rw_i),
        .dc_req_data_i(dc_req_data_i), .dc_req_uncached_i(dc_req_uncached_i),
        .dc_res_valid_o(dc_res_valid_o), .dc_res_blk_o(dc_res_blk_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_rw_o(mem_req_rw_o),
        .mem_req_data_o(mem_req_data_o), .mem_req_uncached_o(mem_req_uncached_o),
        .mem_res_valid_i(mem_res_valid_i), .mem_res_blk_i(mem_res_blk_i)
    );

    // Memory answers for one cycle; a pulse is expected only for a live transaction.
    task automatic mem_respond(input bit dc_owner, input logic [127:0] blk, input bit expect_pulse);
        exp_t x;
        mem_res_valid_i = 1'b1;
        mem_res_blk_i   = blk;
        if (expect_pulse) begin
            x.dc  = dc_owner;
            x.blk = blk;
            sb.push_back(x);
        end
        @(negedge clk);
        mem_res_valid_i = 1'b0;
        mem_res_blk_i   = '0;
    endtask

    task automatic wait_mem_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (mem_req_valid_o) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        ic_req_valid_i = 0; ic_req_addr_i = '0; ic_req_uncached_i = 0;
        dc_req_valid_i = 0; dc_req_addr_i = '0; dc_req_rw_i = 0; dc_req_data_i = '0; dc_req_uncached_i = 0;
        mem_req_ready_i = 0; mem_res_valid_i = 0; mem_res_blk_i = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ic_req_ready_o, dc_req_ready_o, mem_req_valid_o, mem_req_rw_o, mem_req_uncached_o, ic_res_valid_o, dc_res_valid_o} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, want 0000000", {ic_req_ready_o, dc_req_ready_o, mem_req_valid_o, mem_req_rw_o, mem_req_uncached_o, ic_res_valid_o, dc_res_valid_o});
        end
        vectors++;
        if (mem_req_addr_o !== 32'h0 || mem_req_data_o !== 128'h0 || ic_res_blk_o !== 128'h0 || dc_res_blk_o !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_regs: addr=%h data=%h ic_blk=%h dc_blk=%h, want all zero", mem_req_addr_o, mem_req_data_o, ic_res_blk_o, dc_res_blk_o);
        end
        rst_ni = 1'b1;
        @(negedge clk);
        // First tie after reset: icache wins in round-robin, dcache in fixed priority.
        ic_req_valid_i = 1; dc_req_valid_i = 1;
        #1;
        vectors++;
`ifdef MEM_ARB_DCACHE_PRIO_EN
        if ({ic_req_ready_o, dc_req_ready_o} !== 2'b01) begin
`else
        if ({ic_req_ready_o, dc_req_ready_o} !== 2'b10) begin
`endif
            miscompares++;
            $display("FAIL first_tie: got ic_ready,dc_ready=%b%b", ic_req_ready_o, dc_req_ready_o);
        end
        ic_req_valid_i = 0; dc_req_valid_i = 0;
    endtask

    task automatic test_ic_read;
        bit ok;
        @(negedge clk);
        ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_0040; ic_req_uncached_i = 0;
        dc_req_rw_i = 1; dc_req_data_i = {4{32'h1234_5678}};
        mem_req_ready_i = 1;
        #1;
        vectors++;
        if ({ic_req_ready_o, dc_req_ready_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL ic_ready: got ic,dc=%b%b, want 10", ic_req_ready_o, dc_req_ready_o);
        end
        wait_mem_req(ok);
        ic_req_valid_i = 0;
        vectors++;
        if (!ok || mem_req_addr_o !== 32'h40 || mem_req_rw_o !== 1'b0 || mem_req_data_o !== 128'h0 || mem_req_uncached_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ic_mem_req: valid=%b addr=%h rw=%b data=%h unc=%b, want 1 00000040 0 0 0", mem_req_valid_o, mem_req_addr_o, mem_req_rw_o, mem_req_data_o, mem_req_uncached_o);
        end
        @(negedge clk);
        vectors++;
        if (mem_req_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ic_valid_drop: got mem_req_valid=%b, want 0", mem_req_valid_o);
        end
        mem_respond(1'b0, {4{32'hDEAD_BEEF}}, 1'b1);
        vectors++;
        e = sb.pop_front();
        if ({dc_res_valid_o, ic_res_valid_o} !== (e.dc ? 2'b10 : 2'b01) || ic_res_blk_o !== e.blk) begin
            miscompares++;
            $display("FAIL ic_pulse: got ic_v=%b dc_v=%b ic_blk=%h, want ic pulse blk=%h", ic_res_valid_o, dc_res_valid_o, ic_res_blk_o, e.blk);
        end
        @(negedge clk);
        vectors++;
        if (ic_res_valid_o !== 1'b0 || dc_res_valid_o !== 1'b0 || ic_res_blk_o !== {4{32'hDEAD_BEEF}}) begin
            miscompares++;
            $display("FAIL ic_pulse_end: got ic_v=%b dc_v=%b ic_blk=%h, want 0 0 held", ic_res_valid_o, dc_res_valid_o, ic_res_blk_o);
        end
    endtask

    task automatic test_dc_write;
        bit ok;
        @(negedge clk);
        dc_req_valid_i = 1; dc_req_addr_i = 32'h1000_0000; dc_req_rw_i = 1;
        dc_req_data_i = {4{32'hCAFE_BABE}}; dc_req_uncached_i = 0;
        wait_mem_req(ok);
        dc_req_valid_i = 0;
        vectors++;
        if (!ok || mem_req_addr_o !== 32'h1000_0000 || mem_req_rw_o !== 1'b1 || mem_req_data_o !== {4{32'hCAFE_BABE}}) begin
            miscompares++;
            $display("FAIL dc_mem_req: valid=%b addr=%h rw=%b data=%h", mem_req_valid_o, mem_req_addr_o, mem_req_rw_o, mem_req_data_o);
        end
        @(negedge clk);
        mem_respond(1'b1, {4{32'hA5A5_0001}}, 1'b1);
        vectors++;
        e = sb.pop_front();
        if ({dc_res_valid_o, ic_res_valid_o} !== (e.dc ? 2'b10 : 2'b01) || dc_res_blk_o !== e.blk) begin
            miscompares++;
            $display("FAIL dc_pulse: got ic_v=%b dc_v=%b dc_blk=%h, want dc pulse blk=%h", ic_res_valid_o, dc_res_valid_o, dc_res_blk_o, e.blk);
        end
    endtask

    task automatic test_round_robin;
        bit ok;
        logic [3:0]   order;
        logic [1:0]   want_rdy;
        logic [127:0] blk;
`ifdef MEM_ARB_DCACHE_PRIO_EN
        order = 4'b1111;
`else
        order = 4'b1010;
`endif
        @(negedge clk);
        ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_0100; ic_req_uncached_i = 0;
        dc_req_valid_i = 1; dc_req_addr_i = 32'h2000_0100; dc_req_rw_i = 1; dc_req_data_i = {4{32'h0BAD_F00D}};
        mem_req_ready_i = 1;
        #1;
        vectors++;
        want_rdy = order[0] ? 2'b01 : 2'b10;
        if ({ic_req_ready_o, dc_req_ready_o} !== want_rdy) begin
            miscompares++;
            $display("FAIL rr_ready_0: got ic,dc=%b%b, want %b", ic_req_ready_o, dc_req_ready_o, want_rdy);
        end
        for (int i = 0; i < 4; i++) begin
            wait_mem_req(ok);
            vectors++;
            if (!ok || mem_req_addr_o !== (order[i] ? 32'h2000_0100 : 32'h0000_0100) || mem_req_rw_o !== order[i] ||
                mem_req_data_o !== (order[i] ? {4{32'h0BAD_F00D}} : 128'h0)) begin
                miscompares++;
                $display("FAIL rr_grant_%0d: valid=%b addr=%h rw=%b data=%h, want owner dc=%b", i, mem_req_valid_o, mem_req_addr_o, mem_req_rw_o, mem_req_data_o, order[i]);
            end
            @(negedge clk);
            blk = {32'h0000_0000, 32'hFEED_0000, 32'h1111_2222, 32'(i + 1)};
            mem_respond(order[i], blk, 1'b1);
            vectors++;
            e = sb.pop_front();
            if ({dc_res_valid_o, ic_res_valid_o} !== (e.dc ? 2'b10 : 2'b01) || (e.dc ? dc_res_blk_o : ic_res_blk_o) !== e.blk) begin
                miscompares++;
                $display("FAIL rr_pulse_%0d: got ic_v=%b dc_v=%b ic_blk=%h dc_blk=%h, want dc=%b blk=%h", i, ic_res_valid_o, dc_res_valid_o, ic_res_blk_o, dc_res_blk_o, e.dc, e.blk);
            end
            if (i == 3) begin
                ic_req_valid_i = 0; dc_req_valid_i = 0;
                want_rdy = 2'b00;
            end else begin
                want_rdy = order[i + 1] ? 2'b01 : 2'b10;
            end
            #1;
            vectors++;
            if ({ic_req_ready_o, dc_req_ready_o} !== want_rdy) begin
                miscompares++;
                $display("FAIL rr_ready_%0d: got ic,dc=%b%b, want %b", i + 1, ic_req_ready_o, dc_req_ready_o, want_rdy);
            end
        end
    endtask

    task automatic test_stall;
        bit ok;
        @(negedge clk);
        mem_req_ready_i = 0;
        dc_req_valid_i = 1; dc_req_addr_i = 32'h2000_0000; dc_req_rw_i = 0;
        dc_req_data_i = {4{32'h5555_AAAA}}; dc_req_uncached_i = 1;
        wait_mem_req(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stall_req: got mem_req_valid=%b, want 1", mem_req_valid_o);
        end
        dc_req_valid_i = 0; dc_req_addr_i = 32'hFFFF_FFFF; dc_req_rw_i = 1; dc_req_data_i = '1; dc_req_uncached_i = 0;
        ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_0300;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h2000_0000 || mem_req_rw_o !== 1'b0 ||
                mem_req_data_o !== {4{32'h5555_AAAA}} || mem_req_uncached_o !== 1'b1 || ic_req_ready_o !== 1'b0 || dc_req_ready_o !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_%0d: valid=%b addr=%h rw=%b data=%h unc=%b rdy=%b%b", k, mem_req_valid_o, mem_req_addr_o, mem_req_rw_o, mem_req_data_o, mem_req_uncached_o, ic_req_ready_o, dc_req_ready_o);
            end
        end
        ic_req_valid_i = 0;
        mem_req_ready_i = 1;
        @(negedge clk);
        vectors++;
        if (mem_req_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_release: got mem_req_valid=%b, want 0", mem_req_valid_o);
        end
        mem_respond(1'b1, {4{32'h7777_0003}}, 1'b1);
        vectors++;
        e = sb.pop_front();
        if ({dc_res_valid_o, ic_res_valid_o} !== (e.dc ? 2'b10 : 2'b01) || dc_res_blk_o !== e.blk) begin
            miscompares++;
            $display("FAIL stall_pulse: got ic_v=%b dc_v=%b dc_blk=%h, want dc blk=%h", ic_res_valid_o, dc_res_valid_o, dc_res_blk_o, e.blk);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        @(negedge clk);
        ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_0080; mem_req_ready_i = 1;
        wait_mem_req(ok);
        ic_req_valid_i = 0;
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        vectors++;
        if (!ok || mem_req_valid_o !== 1'b0 || ic_res_valid_o !== 1'b0 || dc_res_valid_o !== 1'b0 || mem_req_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL midrst_clear: ok=%b valid=%b ic_v=%b dc_v=%b addr=%h", ok, mem_req_valid_o, ic_res_valid_o, dc_res_valid_o, mem_req_addr_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        mem_respond(1'b0, {4{32'hBADB_AD00}}, 1'b0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (ic_res_valid_o !== 1'b0 || dc_res_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_late_%0d: got ic_v=%b dc_v=%b mem_v=%b, want 000", k, ic_res_valid_o, dc_res_valid_o, mem_req_valid_o);
            end
            @(negedge clk);
        end
        ic_req_valid_i = 1; ic_req_addr_i = 32'h0000_0044;
        #1;
        vectors++;
        if (ic_req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_regrant: got ic_ready=%b, want 1", ic_req_ready_o);
        end
        wait_mem_req(ok);
        ic_req_valid_i = 0;
        vectors++;
        if (!ok || mem_req_addr_o !== 32'h44) begin
            miscompares++;
            $display("FAIL midrst_req: valid=%b addr=%h, want 1 00000044", mem_req_valid_o, mem_req_addr_o);
        end
        @(negedge clk);
        mem_respond(1'b0, {4{32'h0044_0044}}, 1'b1);
        vectors++;
        e = sb.pop_front();
        if ({dc_res_valid_o, ic_res_valid_o} !== (e.dc ? 2'b10 : 2'b01) || ic_res_blk_o !== e.blk) begin
            miscompares++;
            $display("FAIL midrst_pulse: got ic_v=%b dc_v=%b ic_blk=%h, want ic blk=%h", ic_res_valid_o, dc_res_valid_o, ic_res_blk_o, e.blk);
        end
    endtask

    task automatic test_spurious;
        bit ok;
        @(negedge clk);
        mem_respond(1'b1, {4{32'h5959_5959}}, 1'b0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (ic_res_valid_o !== 1'b0 || dc_res_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0 || dc_res_blk_o === {4{32'h5959_5959}}) begin
                miscompares++;
                $display("FAIL spurious_%0d: got ic_v=%b dc_v=%b mem_v=%b dc_blk=%h", k, ic_res_valid_o, dc_res_valid_o, mem_req_valid_o, dc_res_blk_o);
            end
            @(negedge clk);
        end
        dc_req_valid_i = 1; dc_req_addr_i = 32'h3000_0000; dc_req_rw_i = 0; dc_req_data_i = '0; dc_req_uncached_i = 0;
        #1;
        vectors++;
        if (dc_req_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL spurious_idle: got dc_ready=%b, want 1", dc_req_ready_o);
        end
        wait_mem_req(ok);
        dc_req_valid_i = 0;
        @(negedge clk);
        mem_respond(1'b1, {4{32'h3000_0003}}, 1'b1);
        vectors++;
        e = sb.pop_front();
        if (!ok || {dc_res_valid_o, ic_res_valid_o} !== (e.dc ? 2'b10 : 2'b01) || dc_res_blk_o !== e.blk) begin
            miscompares++;
            $display("FAIL spurious_pulse: ok=%b got ic_v=%b dc_v=%b dc_blk=%h, want dc blk=%h", ok, ic_res_valid_o, dc_res_valid_o, dc_res_blk_o, e.blk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ic_read();
        test_dc_write();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_spurious();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
